// File: rtl/roc_output_sampler.sv
// Redstone output sampler: snapshots the output vector on each synchronized
// tick and streams changed snapshots as framed bytes (A5, tick_lo, tick_hi,
// payload) to a UART transmitter. Holds one pending frame while busy.
module roc_output_sampler #(
  parameter int unsigned ROC_OUTPUTS      = 8,
  parameter int unsigned ROC_OUTPUT_BYTES = (ROC_OUTPUTS + 7) >> 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_tick,
  input  logic [ROC_OUTPUTS-1:0] i_roc_outputs,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [15:0]            o_tick_cnt,
  output logic [7:0]             o_drop_cnt,
  output logic                   o_busy
);

  localparam int unsigned PayW = 8 * ROC_OUTPUT_BYTES;
  localparam int unsigned IdxW = (ROC_OUTPUT_BYTES > 1) ? $clog2(ROC_OUTPUT_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ROC_OUTPUT_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StCntLo, StCntHi, StData} state_e;

  state_e            r_state, w_state_nxt;
  logic [IdxW-1:0]   r_idx, w_idx_nxt;
  logic              r_sync1, r_sync2, r_hist;
  logic [15:0]       r_tick_cnt;
  logic [7:0]        r_drop_cnt;
  logic [15:0]       r_frm_tick, r_pend_tick;
  logic [PayW-1:0]   r_frm_data, r_pend_data, r_ref;
  logic              r_pending, r_first;

  logic              w_tick_p, w_changed, w_accept, w_last;
  logic [15:0]       w_tick_nxt;
  logic [PayW-1:0]   w_snap;
  logic [7:0]        w_data_byte;
  logic              w_load_new, w_load_pend, w_store_pend, w_clr_pend, w_drop;

  // Zero-pad the output vector up to whole payload bytes.
  always_comb begin
    w_snap = '0;
    w_snap[ROC_OUTPUTS-1:0] = i_roc_outputs;
  end

  assign w_tick_p   = r_sync2 & ~r_hist;
  assign w_tick_nxt = r_tick_cnt + 16'd1;
  assign w_changed  = w_tick_p & (r_first | (w_snap != r_ref));
  assign w_accept   = o_tx_valid & i_tx_ready;
  assign w_last     = (r_state == StData) & w_accept & (r_idx == LastIdx);

  // Next-state and buffer control; last-byte handling overrides the plain advance.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_load_new   = 1'b0;
    w_load_pend  = 1'b0;
    w_store_pend = 1'b0;
    w_clr_pend   = 1'b0;
    w_drop       = 1'b0;
    unique case (r_state)
      StIdle:  if (w_changed) begin
                 w_state_nxt = StHdr;
                 w_load_new  = 1'b1;
               end
      StHdr:   if (w_accept) w_state_nxt = StCntLo;
      StCntLo: if (w_accept) w_state_nxt = StCntHi;
      StCntHi: if (w_accept) begin
                 w_state_nxt = StData;
                 w_idx_nxt   = '0;
               end
      StData:  if (w_accept && (r_idx != LastIdx)) w_idx_nxt = r_idx + IdxW'(1);
      default: w_state_nxt = StIdle;
    endcase
    if (w_last) begin
      if (r_pending) begin
        // Older pending snapshot goes first; a simultaneous new one takes its slot.
        w_load_pend = 1'b1;
        w_state_nxt = StHdr;
        if (w_changed) w_store_pend = 1'b1;
        else           w_clr_pend   = 1'b1;
      end else if (w_changed) begin
        w_load_new  = 1'b1;
        w_state_nxt = StHdr;
      end else begin
        w_state_nxt = StIdle;
      end
    end else if ((r_state != StIdle) && w_changed) begin
      w_store_pend = 1'b1;
      w_drop       = r_pending;
    end
  end

  // Select the payload byte addressed by the DATA index.
  always_comb begin
    w_data_byte = 8'h00;
    for (int b = 0; b < ROC_OUTPUT_BYTES; b++) begin
      if (r_idx == IdxW'(b)) w_data_byte = r_frm_data[8*b +: 8];
    end
  end

  // Byte presented to the transmitter; only frame registers feed it, so it stays stable.
  always_comb begin
    o_tx_data = 8'h00;
    unique case (r_state)
      StHdr:   o_tx_data = 8'hA5;
      StCntLo: o_tx_data = r_frm_tick[7:0];
      StCntHi: o_tx_data = r_frm_tick[15:8];
      StData:  o_tx_data = w_data_byte;
      default: o_tx_data = 8'h00;
    endcase
  end

  assign o_tx_valid = (r_state != StIdle);
  assign o_busy     = (r_state != StIdle) | r_pending;
  assign o_tick_cnt = r_tick_cnt;
  assign o_drop_cnt = r_drop_cnt;

  // State, synchronizer, counters and frame/pending buffers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_hist      <= 1'b0;
      r_tick_cnt  <= 16'h0000;
      r_drop_cnt  <= 8'h00;
      r_frm_tick  <= 16'h0000;
      r_frm_data  <= '0;
      r_pend_tick <= 16'h0000;
      r_pend_data <= '0;
      r_ref       <= '0;
      r_pending   <= 1'b0;
      r_first     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sync1 <= i_tick;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (w_tick_p) r_tick_cnt <= w_tick_nxt;
      if (w_changed) begin
        r_ref   <= w_snap;
        r_first <= 1'b0;
      end
      if (w_load_new) begin
        r_frm_tick <= w_tick_nxt;
        r_frm_data <= w_snap;
      end else if (w_load_pend) begin
        r_frm_tick <= r_pend_tick;
        r_frm_data <= r_pend_data;
      end
      if (w_store_pend) begin
        r_pend_tick <= w_tick_nxt;
        r_pend_data <= w_snap;
        r_pending   <= 1'b1;
      end else if (w_clr_pend) begin
        r_pending <= 1'b0;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_roc_output_sampler.sv
// Scoreboard bench for roc_output_sampler (12 outputs, 2 payload bytes).
module tb_roc_output_sampler;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_tick = 1'b0;
  logic [11:0] i_roc_outputs = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic [15:0] o_tick_cnt;
  logic [7:0]  o_drop_cnt;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  roc_output_sampler #(
    .ROC_OUTPUTS     (12),
    .ROC_OUTPUT_BYTES(2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_tick       (i_tick),
    .i_roc_outputs(i_roc_outputs),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_tick_cnt   (o_tick_cnt),
    .o_drop_cnt   (o_drop_cnt),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (!i_rst && o_tx_valid && i_tx_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no byte", o_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_byte: got 0x%0h, expected 0x%0h", o_tx_data, e);
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] b0, b1, b2, b3, b4);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b4);
  endtask

  task automatic do_tick(input logic [11:0] v);
    @(posedge clk); #1;
    i_roc_outputs = v;
    i_tick = 1'b1;
    repeat (4) @(posedge clk);
    #1 i_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((o_busy || o_tx_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, n);
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(o_tx_valid), 32'h0);
    check("rst_data", 32'(o_tx_data), 32'h00);
    check("rst_tick", 32'(o_tick_cnt), 32'h0);
    check("rst_drop", 32'(o_drop_cnt), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);

    // First tick always sends, even with all-zero outputs
    push_frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h00);
    do_tick(12'h000);
    wait_idle("first");
    check("first_tick_cnt", 32'(o_tick_cnt), 32'h1);

    // Unchanged tick is silent; changed tick sends
    do_tick(12'h000);
    push_frame(8'hA5, 8'h03, 8'h00, 8'hBC, 8'h0A);
    do_tick(12'hABC);
    wait_idle("change");
    check("change_tick_cnt", 32'(o_tick_cnt), 32'h3);
    check("change_drop", 32'(o_drop_cnt), 32'h0);

    // Backpressure in HDR: byte held stable
    i_tx_ready = 1'b0;
    push_frame(8'hA5, 8'h04, 8'h00, 8'h23, 8'h01);
    do_tick(12'h123);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(o_tx_valid), 32'h1);
      check("stall_data", 32'(o_tx_data), 32'hA5);
    end
    @(posedge clk); #1 i_tx_ready = 1'b1;
    wait_idle("stall");

    // Three changed ticks in one frame: one drop, third sent gaplessly
    i_tx_ready = 1'b0;
    push_frame(8'hA5, 8'h05, 8'h00, 8'h11, 8'h01);
    do_tick(12'h111);
    do_tick(12'h222);
    push_frame(8'hA5, 8'h07, 8'h00, 8'h33, 8'h03);
    do_tick(12'h333);
    check("drop_cnt", 32'(o_drop_cnt), 32'h1);
    check("drop_busy", 32'(o_busy), 32'h1);
    @(posedge clk); #1 i_tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("gapless_valid", 32'(o_tx_valid), 32'h1);
    end
    @(negedge clk);
    check("gapless_end_valid", 32'(o_tx_valid), 32'h0);
    check("gapless_end_busy", 32'(o_busy), 32'h0);

    // Tick counter wrap (counter preset to 0xFFFF)
    @(posedge clk); #1;
    force dut.r_tick_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_tick_cnt;
    check("preset_tick", 32'(o_tick_cnt), 32'hFFFF);
    push_frame(8'hA5, 8'h00, 8'h00, 8'h56, 8'h04);
    do_tick(12'h456);
    check("wrap_tick_cnt", 32'(o_tick_cnt), 32'h0);
    wait_idle("wrap");

    // Reset in CNT_HI with a pending snapshot
    i_tx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    do_tick(12'h789);
    do_tick(12'h78A);
    check("mid_pending_busy", 32'(o_busy), 32'h1);
    i_tx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 i_tx_ready = 1'b0;
    @(negedge clk);
    check("cnthi_valid", 32'(o_tx_valid), 32'h1);
    check("cnthi_data", 32'(o_tx_data), 32'h00);
    @(posedge clk); #1 i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(o_tx_valid), 32'h0);
    check("midrst_busy", 32'(o_busy), 32'h0);
    check("midrst_data", 32'(o_tx_data), 32'h00);
    check("midrst_tick", 32'(o_tick_cnt), 32'h0);
    check("midrst_drop", 32'(o_drop_cnt), 32'h0);
    i_tx_ready = 1'b1;
    push_frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h00);
    do_tick(12'h000);
    wait_idle("post_rst");
    check("post_rst_tick", 32'(o_tick_cnt), 32'h1);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
